// File: rtl/ether_udp_rx_filter.sv
// GMII receive filter: passes only UDP/IPv4 frames addressed to this station, IP and port,
// and latches the leading payload bytes when a frame ends cleanly.
module ether_udp_rx_filter #(
    parameter logic [47:0]                  MAC_ADDR      = 48'h00301ba0a470,
    parameter logic [31:0]                  IP_ADDR       = 32'hAC100064,
    parameter logic [15:0]                  UDP_PORT      = 16'd8888,
    parameter int unsigned                  PAYLOAD_BYTES = 1,
    parameter bit                           CHECK_FCS     = 1'b1,
    parameter bit                           ACCEPT_BCAST  = 1'b0,
    parameter logic [8*PAYLOAD_BYTES-1:0]   DATA_INIT     = '0
) (
    input  logic                            phy_rx_clk,
    input  logic                            rst,
    input  logic                            id,
    input  logic                            phy_rx_dv,
    input  logic                            phy_rx_er,
    input  logic [7:0]                      phy_rx_data,
    output logic [8*PAYLOAD_BYTES-1:0]      data_out,
    output logic                            data_valid,
    output logic [15:0]                     frame_cnt,
    output logic [15:0]                     drop_cnt
);

    localparam int unsigned PW          = 8 * PAYLOAD_BYTES;
    localparam logic [10:0] PAY_FIRST   = 11'd42;
    localparam logic [10:0] PAY_LAST    = 11'(41 + PAYLOAD_BYTES);
    localparam logic [10:0] MIN_LEN     = 11'(46 + PAYLOAD_BYTES);
    localparam logic [10:0] MAX_LEN     = 11'd1522;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {IDLE, PRE, BODY, DROP} state_t;

    state_t           r_state,      w_state_nxt;
    logic [2:0]       r_pre_cnt,    w_pre_nxt;
    logic [10:0]      r_offset,     w_offset_nxt;
    logic [31:0]      r_crc,        w_crc_nxt;
    logic             r_frame_ok,   w_frame_ok_nxt;
    logic             r_uc_ok,      w_uc_nxt;
    logic             r_bc_ok,      w_bc_nxt;
    logic [PW-1:0]    r_shadow,     w_shadow_nxt;
    logic [PW-1:0]    r_data_out,   w_data_out_nxt;
    logic             r_data_valid, w_valid_nxt;
    logic [15:0]      r_frame_cnt,  w_frame_cnt_nxt;
    logic [15:0]      r_drop_cnt,   w_drop_cnt_nxt;

    logic [47:0]      w_eff_mac;
    logic [7:0]       w_mac_byte;
    logic             w_uc_hit;
    logic             w_bc_hit;
    logic             w_hdr_bad;
    logic             w_accept;
    logic [PW+7:0]    w_shift;

    // Data bits enter LSB first into an MSB-first register, so a good frame leaves CRC_RESIDUE.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
        end
        return c;
    endfunction

    assign w_eff_mac = MAC_ADDR ^ {47'd0, id};
    assign w_shift   = {r_shadow, phy_rx_data};
    assign w_accept  = r_frame_ok && (r_offset >= MIN_LEN) && (r_offset <= MAX_LEN) &&
                       (!CHECK_FCS || (r_crc == CRC_RESIDUE));

    always_comb begin
        w_mac_byte = 8'h00;
        case (r_offset[2:0])
            3'd0:    w_mac_byte = w_eff_mac[47:40];
            3'd1:    w_mac_byte = w_eff_mac[39:32];
            3'd2:    w_mac_byte = w_eff_mac[31:24];
            3'd3:    w_mac_byte = w_eff_mac[23:16];
            3'd4:    w_mac_byte = w_eff_mac[15:8];
            3'd5:    w_mac_byte = w_eff_mac[7:0];
            default: w_mac_byte = 8'h00;
        endcase
        // Unicast and broadcast matches are tracked separately so mixed addresses fail.
        w_uc_hit  = r_uc_ok && (phy_rx_data == w_mac_byte);
        w_bc_hit  = r_bc_ok && (phy_rx_data == 8'hFF);
        w_hdr_bad = 1'b0;
        case (r_offset)
            11'd0, 11'd1, 11'd2,
            11'd3, 11'd4, 11'd5: w_hdr_bad = !(w_uc_hit || w_bc_hit);
            11'd12:  w_hdr_bad = (phy_rx_data != 8'h08);
            11'd13:  w_hdr_bad = (phy_rx_data != 8'h00);
            11'd14:  w_hdr_bad = (phy_rx_data != 8'h45);
            11'd23:  w_hdr_bad = (phy_rx_data != 8'h11);
            11'd30:  w_hdr_bad = (phy_rx_data != IP_ADDR[31:24]);
            11'd31:  w_hdr_bad = (phy_rx_data != IP_ADDR[23:16]);
            11'd32:  w_hdr_bad = (phy_rx_data != IP_ADDR[15:8]);
            11'd33:  w_hdr_bad = (phy_rx_data != IP_ADDR[7:0]);
            11'd36:  w_hdr_bad = (phy_rx_data != UDP_PORT[15:8]);
            11'd37:  w_hdr_bad = (phy_rx_data != UDP_PORT[7:0]);
            default: w_hdr_bad = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pre_nxt       = r_pre_cnt;
        w_offset_nxt    = r_offset;
        w_crc_nxt       = r_crc;
        w_frame_ok_nxt  = r_frame_ok;
        w_uc_nxt        = r_uc_ok;
        w_bc_nxt        = r_bc_ok;
        w_shadow_nxt    = r_shadow;
        w_data_out_nxt  = r_data_out;
        w_valid_nxt     = 1'b0;
        w_frame_cnt_nxt = r_frame_cnt;
        w_drop_cnt_nxt  = r_drop_cnt;

        if (!phy_rx_dv) begin
            if (r_state == BODY && w_accept) begin
                w_data_out_nxt  = r_shadow;
                w_valid_nxt     = 1'b1;
                w_frame_cnt_nxt = r_frame_cnt + 16'd1;
            end else if (r_state == BODY || (r_state == DROP && r_offset != 11'd0)) begin
                w_drop_cnt_nxt  = r_drop_cnt + 16'd1;
            end
            w_state_nxt    = IDLE;
            w_pre_nxt      = 3'd0;
            w_offset_nxt   = 11'd0;
            w_crc_nxt      = 32'hFFFFFFFF;
            w_frame_ok_nxt = 1'b0;
            w_uc_nxt       = 1'b1;
            w_bc_nxt       = ACCEPT_BCAST;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (phy_rx_data == 8'h55) begin
                        w_state_nxt = PRE;
                        w_pre_nxt   = 3'd1;
                    end else begin
                        w_state_nxt = DROP;
                    end
                end
                PRE: begin
                    if (phy_rx_er) begin
                        w_state_nxt = DROP;
                    end else if (phy_rx_data == 8'h55) begin
                        if (r_pre_cnt == 3'd7) w_state_nxt = DROP;
                        else                   w_pre_nxt   = r_pre_cnt + 3'd1;
                    end else if (phy_rx_data == 8'hD5) begin
                        w_state_nxt    = BODY;
                        w_offset_nxt   = 11'd0;
                        w_crc_nxt      = 32'hFFFFFFFF;
                        w_frame_ok_nxt = 1'b1;
                        w_uc_nxt       = 1'b1;
                        w_bc_nxt       = ACCEPT_BCAST;
                    end else begin
                        w_state_nxt = DROP;
                    end
                end
                BODY: begin
                    w_crc_nxt = crc_byte(r_crc, phy_rx_data);
                    if (r_offset != 11'h7FF) w_offset_nxt = r_offset + 11'd1;
                    if (r_offset >= PAY_FIRST && r_offset <= PAY_LAST) begin
                        w_shadow_nxt = w_shift[PW-1:0];
                    end
                    if (r_offset <= 11'd5) begin
                        w_uc_nxt = w_uc_hit;
                        w_bc_nxt = w_bc_hit;
                    end
                    if (phy_rx_er || w_hdr_bad) begin
                        w_frame_ok_nxt = 1'b0;
                        w_state_nxt    = DROP;
                    end
                end
                DROP: ;
            endcase
        end
    end

    always_ff @(posedge phy_rx_clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pre_cnt    <= 3'd0;
            r_offset     <= 11'd0;
            r_crc        <= 32'hFFFFFFFF;
            r_frame_ok   <= 1'b0;
            r_uc_ok      <= 1'b1;
            r_bc_ok      <= ACCEPT_BCAST;
            r_shadow     <= '0;
            r_data_out   <= DATA_INIT;
            r_data_valid <= 1'b0;
            r_frame_cnt  <= 16'd0;
            r_drop_cnt   <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pre_cnt    <= w_pre_nxt;
            r_offset     <= w_offset_nxt;
            r_crc        <= w_crc_nxt;
            r_frame_ok   <= w_frame_ok_nxt;
            r_uc_ok      <= w_uc_nxt;
            r_bc_ok      <= w_bc_nxt;
            r_shadow     <= w_shadow_nxt;
            r_data_out   <= w_data_out_nxt;
            r_data_valid <= w_valid_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_drop_cnt   <= w_drop_cnt_nxt;
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_cnt  = r_frame_cnt;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_ether_udp_rx_filter.sv
// Randomized frame bench for ether_udp_rx_filter: two configurations share one GMII stream,
// a frame-level reference model predicts each verdict and a monitor checks every commit pulse.
module tb_ether_udp_rx_filter;

    localparam logic [47:0] MAC   = 48'h00301ba0a470;
    localparam logic [31:0] IP    = 32'hAC100064;
    localparam logic [15:0] PORT  = 16'd8888;
    localparam logic [63:0] INIT1 = 64'h00000000DEADBEEF;

    logic        clk;
    logic        rst;
    logic        cur_id;
    logic        dv;
    logic        er;
    logic [7:0]  data;
    logic [7:0]  data_out0;
    logic [31:0] data_out1;
    logic        valid0, valid1;
    logic [15:0] fcnt0, fcnt1, dcnt0, dcnt1;

    int          errors;
    int          checks;
    logic [7:0]  fr[$];
    int          er_idx;
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [15:0] exp_frame[2];
    logic [15:0] exp_drop[2];
    logic [63:0] last_data[2];

    ether_udp_rx_filter u_dut0 (
        .phy_rx_clk  (clk),
        .rst         (rst),
        .id          (cur_id),
        .phy_rx_dv   (dv),
        .phy_rx_er   (er),
        .phy_rx_data (data),
        .data_out    (data_out0),
        .data_valid  (valid0),
        .frame_cnt   (fcnt0),
        .drop_cnt    (dcnt0)
    );

    ether_udp_rx_filter #(
        .PAYLOAD_BYTES (4),
        .CHECK_FCS     (1'b0),
        .ACCEPT_BCAST  (1'b1),
        .DATA_INIT     (32'hDEADBEEF)
    ) u_dut1 (
        .phy_rx_clk  (clk),
        .rst         (rst),
        .id          (cur_id),
        .phy_rx_dv   (dv),
        .phy_rx_er   (er),
        .phy_rx_data (data),
        .data_out    (data_out1),
        .data_valid  (valid1),
        .frame_cnt   (fcnt1),
        .drop_cnt    (dcnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Standard reflected Ethernet CRC-32 before final inversion.
    function automatic logic [31:0] crc32(input logic [7:0] q[$], input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) begin
            c = c ^ {24'd0, q[k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // kinds: 0 good, 1 bad FCS, 2 port 8889, 3 bad IP, 4 wrong MAC LSB, 5 broadcast,
    // 6 bad ethertype, 7 rx_er in body, 8 eight-byte preamble, 9 bad SFD,
    // 10 bad IP version, 11 TCP protocol, 12 short preamble
    task automatic build_frame(input int kind, input int npay, input logic [31:0] head,
                               input int nhead, input int er_at);
        logic [7:0]  bq[$];
        logic [47:0] dst;
        logic [31:0] ip;
        logic [15:0] port;
        logic [31:0] fcs;
        int          npre;
        fr.delete();
        dst = MAC ^ {47'd0, cur_id};
        if (kind == 4) dst = dst ^ 48'h1;
        if (kind == 5) dst = '1;
        for (int k = 0; k < 6; k++) bq.push_back(dst[47-8*k -: 8]);
        for (int k = 0; k < 6; k++) bq.push_back(8'($urandom));
        bq.push_back((kind == 6) ? 8'h86 : 8'h08);
        bq.push_back(8'h00);
        bq.push_back((kind == 10) ? 8'h46 : 8'h45);
        for (int k = 0; k < 8; k++) bq.push_back(8'($urandom));
        bq.push_back((kind == 11) ? 8'h06 : 8'h11);
        for (int k = 0; k < 6; k++) bq.push_back(8'($urandom));
        ip = (kind == 3) ? (IP ^ 32'h1) : IP;
        for (int k = 0; k < 4; k++) bq.push_back(ip[31-8*k -: 8]);
        for (int k = 0; k < 2; k++) bq.push_back(8'($urandom));
        port = (kind == 2) ? 16'd8889 : PORT;
        bq.push_back(port[15:8]);
        bq.push_back(port[7:0]);
        for (int k = 0; k < 4; k++) bq.push_back(8'($urandom));
        for (int k = 0; k < npay; k++)
            bq.push_back((k < nhead) ? head[31-8*k -: 8] : 8'($urandom));
        fcs = ~crc32(bq, bq.size());
        for (int k = 0; k < 4; k++) bq.push_back(fcs[8*k +: 8]);
        if (kind == 1) bq[bq.size()-1] = bq[bq.size()-1] ^ 8'h01;
        npre = (kind == 8) ? 8 : ((kind == 12) ? int'($urandom_range(1, 7)) : 7);
        for (int k = 0; k < npre; k++) fr.push_back(8'h55);
        fr.push_back((kind == 9) ? 8'h57 : 8'hD5);
        for (int k = 0; k < bq.size(); k++) fr.push_back(bq[k]);
        er_idx = (er_at < 0) ? -1 : (npre + 1 + er_at);
    endtask

    // Frame-level verdict: 0 ignored (preamble fault), 1 rejected, 2 accepted.
    function automatic void model_eval(input int pb, input bit chk, input bit bc,
                                       output int verdict, output logic [63:0] pay);
        logic [7:0]  body[$];
        logic [47:0] dst;
        logic [31:0] fcs;
        int          i;
        int          len;
        bit          ok;
        verdict = 0;
        pay     = '0;
        i       = 0;
        while (i < fr.size() && fr[i] == 8'h55) i++;
        if (i < 1 || i > 7 || i >= fr.size() || fr[i] != 8'hD5) return;
        if (er_idx >= 0 && er_idx <= i) return;
        for (int k = i + 1; k < fr.size(); k++) body.push_back(fr[k]);
        len     = body.size();
        verdict = 1;
        if (er_idx > i) return;
        if (len < 46 + pb || len > 1522) return;
        dst = '0;
        for (int k = 0; k < 6; k++) dst = {dst[39:0], body[k]};
        ok = (dst == (MAC ^ {47'd0, cur_id})) || (bc && dst == '1);
        ok = ok && body[12] == 8'h08 && body[13] == 8'h00 && body[14] == 8'h45 &&
             body[23] == 8'h11;
        ok = ok && ({body[30], body[31], body[32], body[33]} == IP);
        ok = ok && ({body[36], body[37]} == PORT);
        if (chk) begin
            fcs = ~crc32(body, len - 4);
            ok  = ok && ({body[len-1], body[len-2], body[len-3], body[len-4]} == fcs);
        end
        if (!ok) return;
        verdict = 2;
        for (int k = 0; k < pb; k++) pay = {pay[55:0], body[42+k]};
    endfunction

    task automatic expect_frame(input int d, input int verdict, input logic [63:0] pay);
        if (verdict == 2) begin
            if (d == 0) q0.push_back(pay);
            else        q1.push_back(pay);
            exp_frame[d] = exp_frame[d] + 16'd1;
            last_data[d] = pay;
        end else if (verdict == 1) begin
            exp_drop[d] = exp_drop[d] + 16'd1;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, " frame_cnt0"}, {48'd0, fcnt0}, {48'd0, exp_frame[0]});
        check({tag, " drop_cnt0"},  {48'd0, dcnt0}, {48'd0, exp_drop[0]});
        check({tag, " data_out0"},  {56'd0, data_out0}, last_data[0]);
        check({tag, " frame_cnt1"}, {48'd0, fcnt1}, {48'd0, exp_frame[1]});
        check({tag, " drop_cnt1"},  {48'd0, dcnt1}, {48'd0, exp_drop[1]});
        check({tag, " data_out1"},  {32'd0, data_out1}, last_data[1]);
    endtask

    task automatic run_frame(input string tag, input int gap);
        int          v;
        logic [63:0] p;
        model_eval(1, 1'b1, 1'b0, v, p);
        expect_frame(0, v, p);
        model_eval(4, 1'b0, 1'b1, v, p);
        expect_frame(1, v, p);
        for (int k = 0; k < fr.size(); k++) begin
            @(negedge clk);
            dv   = 1'b1;
            data = fr[k];
            er   = (k == er_idx);
        end
        @(negedge clk);
        dv   = 1'b0;
        er   = 1'b0;
        data = 8'h00;
        @(negedge clk);
        check_state(tag);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic reset_model();
        exp_frame[0] = 16'd0;
        exp_frame[1] = 16'd0;
        exp_drop[0]  = 16'd0;
        exp_drop[1]  = 16'd0;
        last_data[0] = 64'd0;
        last_data[1] = INIT1;
        q0.delete();
        q1.delete();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid0) begin
                if (q0.size() == 0) check("dut0 unexpected data_valid", 64'd1, 64'd0);
                else                check("dut0 data_out", {56'd0, data_out0}, q0.pop_front());
            end
            if (valid1) begin
                if (q1.size() == 0) check("dut1 unexpected data_valid", 64'd1, 64'd0);
                else                check("dut1 data_out", {32'd0, data_out1}, q1.pop_front());
            end
        end
    end

    initial begin
        int kind;
        int npay;
        int er_at;
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        dv     = 1'b0;
        er     = 1'b0;
        data   = 8'h00;
        cur_id = 1'b0;
        er_idx = -1;
        reset_model();
        repeat (3) @(negedge clk);
        check_state("reset");
        check("reset data_valid", {62'd0, valid1, valid0}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        build_frame(0, 1, 32'h2A000000, 1, -1);
        run_frame("good 2A", 1);
        build_frame(1, 4, 32'h01020304, 4, -1);
        run_frame("bad fcs", 2);
        build_frame(2, 4, 32'h0, 0, -1);
        run_frame("port 8889", 1);
        cur_id = 1'b1;
        build_frame(4, 4, 32'h0, 0, -1);
        run_frame("id1 mac lsb0", 1);
        build_frame(0, 4, 32'h11223344, 4, -1);
        run_frame("id1 payload 11223344", 1);
        cur_id = 1'b0;
        build_frame(7, 6, 32'h0, 0, 20);
        run_frame("rx_er at 20", 1);
        build_frame(0, 5, 32'hA1B2C3D4, 4, -1);
        run_frame("after rx_er", 1);
        build_frame(8, 4, 32'h0, 0, -1);
        run_frame("8-byte preamble", 1);
        build_frame(0, 4, 32'h55667788, 4, -1);
        run_frame("after long preamble", 1);
        build_frame(0, 0, 32'h0, 0, -1);
        run_frame("too short", 1);
        build_frame(0, 1476, 32'hCAFEF00D, 4, -1);
        run_frame("len 1522", 1);
        build_frame(0, 1477, 32'h0, 0, -1);
        run_frame("len 1523", 1);
        build_frame(5, 6, 32'h0, 0, -1);
        run_frame("broadcast", 1);

        // Abandon a frame with an asynchronous reset, then resume.
        build_frame(0, 8, 32'h0, 0, -1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 30) begin
                rst = 1'b1;
                #1;
                reset_model();
                check_state("async reset");
            end
            if (k == 34) rst = 1'b0;
            dv   = 1'b1;
            er   = 1'b0;
            data = (k >= 34) ? 8'h00 : fr[k];
        end
        @(negedge clk);
        dv   = 1'b0;
        data = 8'h00;
        @(negedge clk);
        check_state("after mid-frame reset");
        build_frame(0, 4, 32'h0BADCAFE, 4, -1);
        run_frame("resume after reset", 1);

        for (int n = 0; n < 150; n++) begin
            kind   = int'($urandom_range(0, 19));
            if (kind > 12) kind = 0;
            npay   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1474, 1478))
                                                  : int'($urandom_range(0, 12));
            cur_id = 1'($urandom_range(0, 1));
            er_at  = (kind == 7) ? int'($urandom_range(0, 45 + npay)) : -1;
            build_frame(kind, npay, 32'h0, 0, er_at);
            run_frame($sformatf("random %0d kind %0d", n, kind), int'($urandom_range(1, 3)));
        end

        repeat (4) @(negedge clk);
        check("dut0 pending commits", 64'(q0.size()), 64'd0);
        check("dut1 pending commits", 64'(q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
